// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory port scheduler.
// The state enum and the data value returned on a bus timeout.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int          TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] ERR_DATA        = 32'h0;

endpackage

// File: rtl/mem_timeout_counter.sv
// Down-counter that flags a memory access left unanswered for TIMEOUT cycles.
// Reloads while clear is high; expired is asserted in the TIMEOUT-th enabled cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(TIMEOUT - 1);
        end else if (enable && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/mem_port_scheduler.sv
// Serialises instruction fetch and data access onto one shared memory port.
// Define MEM_TIMEOUT_EN to abort accesses that see no m_ready within TIMEOUT cycles.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int bus     = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           if_req,
    input  logic [bus-1:0] if_addr,
    output logic [bus-1:0] if_data,
    output logic           if_valid,
    input  logic           d_re,
    input  logic           d_we,
    input  logic [bus-1:0] d_addr,
    input  logic [bus-1:0] d_wdata,
    output logic [bus-1:0] d_rdata,
    output logic           d_valid,
    output logic           m_req,
    output logic           m_we,
    output logic [bus-1:0] m_addr,
    output logic [bus-1:0] m_wdata,
    input  logic [bus-1:0] m_rdata,
    input  logic           m_ready,
    output logic           stall,
    output logic           bus_error
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port_scheduler: TIMEOUT must be at least 1");
    end

    sched_state_t state, state_nxt;
    logic         f_done, d_done;
    logic         want_if, want_d, in_xfer, timeout_hit, xfer_end;

    assign want_if  = if_req & ~f_done;
    assign want_d   = (d_re | d_we) & ~d_done;
    assign stall    = want_if | want_d;
    assign in_xfer  = (state == FETCH) || (state == DATA);
    assign xfer_end = in_xfer & (m_ready | timeout_hit);

`ifdef MEM_TIMEOUT_EN
    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (~in_xfer),
        .enable  (in_xfer),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_error <= 1'b0;
        end else if (in_xfer && !m_ready && timeout_hit) begin
            bus_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (want_if)               state_nxt = FETCH;
                else if (want_d)           state_nxt = DATA;
                else if (f_done || d_done) state_nxt = DONE;
            end
            FETCH, DATA: if (m_ready || timeout_hit) state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flags are cleared on the way into DONE so stall rises again during DONE,
    // giving the processor exactly one low-stall cycle per step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_done   <= 1'b0;
            d_done   <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_data  <= '0;
            if_valid <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (want_if) begin
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                    end else if (want_d) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (f_done || d_done) begin
                        f_done <= 1'b0;
                        d_done <= 1'b0;
                    end
                end
                FETCH: begin
                    if (xfer_end) begin
                        m_req    <= 1'b0;
                        if_data  <= m_ready ? m_rdata : bus'(ERR_DATA);
                        if_valid <= 1'b1;
                        f_done   <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer_end) begin
                        m_req   <= 1'b0;
                        d_valid <= 1'b1;
                        d_done  <= 1'b1;
                        if (!m_we) d_rdata <= m_ready ? m_rdata : bus'(ERR_DATA);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed self-checking bench for mem_port_scheduler.
// The timeout scenario is exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_re, d_we, m_ready;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] if_data, d_rdata, m_addr, m_wdata;
    logic        if_valid, d_valid, m_req, m_we, stall, bus_error;

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;
    logic [31:0] last_addr = '0;

    always #5 clk = ~clk;

    mem_port_scheduler #(.bus(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall(stall), .bus_error(bus_error)
    );

    // Completed memory handshakes, as seen by the memory side.
    always @(posedge clk) begin
        if (reset && m_req && m_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_addr <= m_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        if_req = 0; d_re = 0; d_we = 0; m_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        step();
        chk("rst_m_req", m_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_bus_error", bus_error, 0);
        step();
        reset = 1'b1;
        step();

        // Single fetch at 0x40, memory answers after three cycles.
        if_req = 1; if_addr = 32'h40;
        #1 chk("f_stall_pre", stall, 1);
        step();
        chk("f_m_req", m_req, 1);
        chk("f_m_addr", m_addr, 32'h40);
        chk("f_m_we", m_we, 0);
        step();
        step();
        chk("f_m_req_hold", m_req, 1);
        chk("f_m_addr_hold", m_addr, 32'h40);
        m_ready = 1; m_rdata = 32'hE3A01005;
        step();
        chk("f_if_data", if_data, 32'hE3A01005);
        chk("f_if_valid", if_valid, 1);
        chk("f_m_req_drop", m_req, 0);
        chk("f_stall_low", stall, 0);
        m_ready = 0; if_req = 0;
        step();
        chk("f_if_valid_once", if_valid, 0);
        chk("f_stall_done", stall, 0);
        step();
        chk("f_xfer_cnt", 32'(xfer_cnt), 1);
        chk("f_last_addr", last_addr, 32'h40);

        // Fetch then read at 0x100 with m_ready tied high.
        if_req = 1; if_addr = 32'h44; d_re = 1; d_addr = 32'h100;
        m_ready = 1; m_rdata = 32'hAAAA0001;
        step();
        chk("fr_m_addr_f", m_addr, 32'h44);
        chk("fr_stall_1", stall, 1);
        step();
        chk("fr_if_data", if_data, 32'hAAAA0001);
        chk("fr_stall_2", stall, 1);
        chk("fr_m_req_gap", m_req, 0);
        m_rdata = 32'hBBBB0002;
        step();
        chk("fr_m_addr_d", m_addr, 32'h100);
        chk("fr_m_we_d", m_we, 0);
        chk("fr_stall_3", stall, 1);
        step();
        chk("fr_d_rdata", d_rdata, 32'hBBBB0002);
        chk("fr_d_valid", d_valid, 1);
        chk("fr_stall_low", stall, 0);
        if_req = 0; d_re = 0; m_ready = 0;
        step();
        chk("fr_d_valid_once", d_valid, 0);
        step();
        chk("fr_xfer_cnt", 32'(xfer_cnt), 3);
        chk("fr_last_addr", last_addr, 32'h100);

        // Read and write together become a single write.
        d_re = 1; d_we = 1; d_wdata = 32'h12345678; d_addr = 32'h200;
        step();
        chk("w_m_we", m_we, 1);
        chk("w_m_wdata", m_wdata, 32'h12345678);
        chk("w_m_addr", m_addr, 32'h200);
        m_ready = 1; m_rdata = 32'hDEADBEEF;
        step();
        chk("w_d_valid", d_valid, 1);
        chk("w_d_rdata_kept", d_rdata, 32'hBBBB0002);
        chk("w_stall_low", stall, 0);
        d_re = 0; d_we = 0; m_ready = 0;
        step();
        step();
        chk("w_xfer_cnt", 32'(xfer_cnt), 4);

        // Back-to-back fetch steps with m_ready tied high: 4-cycle period.
        if_req = 1; if_addr = 32'h48; m_ready = 1; m_rdata = 32'h00001111;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("b2b_stall_%0d", i), stall, (i % 4 == 2) ? 0 : 1);
            chk($sformatf("b2b_valid_%0d", i), if_valid, (i % 4 == 2) ? 1 : 0);
        end
        if_req = 0; m_ready = 0;
        step();
        chk("b2b_if_data", if_data, 32'h00001111);

`ifdef MEM_TIMEOUT_EN
        // No m_ready at all: abort after 16 cycles of m_req.
        if_req = 1; if_addr = 32'h300;
        step();
        chk("to_m_req_start", m_req, 1);
        for (int i = 2; i <= 16; i++) step();
        chk("to_m_req_16", m_req, 1);
        chk("to_bus_error_pre", bus_error, 0);
        step();
        chk("to_m_req_drop", m_req, 0);
        chk("to_if_data", if_data, 32'h0);
        chk("to_if_valid", if_valid, 1);
        chk("to_bus_error", bus_error, 1);
        if_req = 0;
        step();
        step();
        chk("to_bus_error_sticky", bus_error, 1);
        chk("to_if_valid_once", if_valid, 0);
`endif

        // Reset in the middle of a fetch; a late m_ready must be discarded.
        if_req = 1; if_addr = 32'h80;
        step();
        chk("rf_m_req", m_req, 1);
        reset = 1'b0;
        #1;
        chk("rf_m_req_async", m_req, 0);
        chk("rf_stall_pending", stall, 1);
        chk("rf_bus_error_clr", bus_error, 0);
        if_req = 0;
        step();
        reset = 1'b1;
        m_ready = 1; m_rdata = 32'h00000055;
        step();
        chk("rf_no_if_valid", if_valid, 0);
        chk("rf_if_data", if_data, 0);
        chk("rf_m_req_idle", m_req, 0);
        chk("rf_stall_idle", stall, 0);
        m_ready = 0;
        step();
        chk("rf_no_if_valid2", if_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Sequences the processor's two memory streams (instruction fetch at pcdir, data access at memdir with MRE/MWE) onto one shared single-port memory with variable latency.
- Per processor step, runs the fetch first and then any data access, and holds the processor with a stall output until every access it requested has completed.
- Sits between the processor and the unified memory model.

Parameters:
- bus, 32, data and address width.
- TIMEOUT, 16, maximum cycles waited for m_ready (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; level, held until stall falls.
- if_addr  input  bus  fetch address (pcdir).
- if_data  output  bus  fetched instruction, registered.
- if_valid  output  1  one-cycle pulse when if_data updates.
- d_re  input  1  data read request (MRE).
- d_we  input  1  data write request (MWE).
- d_addr  input  bus  data address (memdir).
- d_wdata  input  bus  store data (memdataout).
- d_rdata  output  bus  load data (memdatain), registered.
- d_valid  output  1  one-cycle pulse on data completion.
- m_req  output  1  memory request, held until m_ready.
- m_we  output  1  memory write enable.
- m_addr  output  bus  memory address, registered.
- m_wdata  output  bus  memory write data, registered.
- m_rdata  input  bus  memory read data, valid with m_ready.
- m_ready  input  1  memory completion strobe.
- stall  output  1  processor hold.
- bus_error  output  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; f_done and d_done flags cleared; timeout counter 0.
- FSM states: IDLE, FETCH, DATA, DONE.
- IDLE: if if_req and not f_done, go to FETCH. Else if (d_re or d_we) and not d_done, go to DATA. Else stay.
- Entering FETCH or DATA registers m_addr, m_wdata and m_we. m_req is high from the next cycle.
- FETCH/DATA: hold m_req, m_addr, m_we and m_wdata stable until m_ready=1.
- On m_ready in FETCH: if_data<=m_rdata; if_valid pulses next cycle; set f_done; go to IDLE.
- On m_ready in DATA: for reads, d_rdata<=m_rdata; d_valid pulses next cycle; set d_done; go to IDLE.
- Writes: d_rdata is unchanged; d_valid still pulses.
- d_re and d_we both high: treated as a write.
- Minimum latency: request seen at edge N, m_req at N+1, m_ready at N+1 gives valid at N+2. One IDLE cycle separates back-to-back transactions.
- stall = (if_req & ~f_done) | ((d_re|d_we) & ~d_done), computed from the registered flags, so stall is low in the cycle after the final completion.
- DONE is entered from IDLE when all requested flags are set and stall=0. DONE clears f_done and d_done and returns to IDLE. This gives one processor step per pass.
- m_ready outside FETCH/DATA is ignored. A late response after reset or after a timeout is discarded.
- Requests deasserted mid-transaction: the transaction still completes; the flag is cleared in DONE.
- Address widths pass through untouched; no alignment or wrap handling in this block.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter runs in FETCH/DATA. If it reaches TIMEOUT with no m_ready:
  - m_req drops.
  - The affected data register loads 32'h0 and valid pulses.
  - The done flag sets and bus_error sets, sticky until reset.
  - State returns to IDLE.
- Undefined: the block waits indefinitely; bus_error is tied 0 and there is no counter logic.

Decomposition:
- Package mem_sched_pkg holds:
  - state enum (IDLE, FETCH, DATA, DONE);
  - TIMEOUT default;
  - ERR_DATA constant 32'h0.
- One sub-module, mem_timeout_counter (clear, enable, expired), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset mid-FETCH with m_ready arriving 1 cycle after release: m_req=0 immediately; no if_valid; stall follows the pending if_req.
- if_req=1, if_addr=0x40, m_ready after 3 cycles with m_rdata=0xE3A01005: if_data=0xE3A01005; if_valid for one cycle; stall falls; exactly one m_req transaction at 0x40.
- if_req plus d_re at d_addr=0x100: fetch transaction first, then read at 0x100. d_rdata=m_rdata, stall held through both, one DONE pass.
- d_re=d_we=1, d_wdata=0x12345678, d_addr=0x200: single transaction with m_we=1 and m_wdata=0x12345678; d_rdata unchanged.
- MEM_TIMEOUT_EN, TIMEOUT=16, m_ready never asserted: after 16 cycles m_req=0, if_data=0, if_valid pulses, bus_error=1 until reset.
- Back-to-back steps with m_ready tied 1: fetch completes every 4 cycles (IDLE, FETCH, IDLE, DONE); stall low exactly one cycle per step.
